uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dato,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 parity_err,
  input  logic                 clr_err
);
  localparam int DIV_RAW = CLK_FREQ / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [1:0]           sync;
  logic                 rx_s, rx_prev, fall;
  logic [2:0]           state;
  logic [DCW-1:0]       div_cnt;
  logic                 tick, mid, maj;
  logic [3:0]           tick_cnt;
  logic                 s6, s7;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 err_wait;
  logic                 push_req;
  logic [DATA_BITS-1:0] push_word;
  logic                 ferr_set, ovf_set;
`ifdef UART_RX_PARITY_EN
  logic                 par;
  logic                 perr_set;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr, rptr, wptr_n, rptr_n;
  logic                 full, pop, do_push;

  assign rx_s = sync[1];
  assign fall = rx_prev & ~rx_s;
  assign tick = (div_cnt == DCW'(DIV - 1));
  assign mid  = tick && (tick_cnt == 4'd8);
  // Samples at ticks 6 and 7 are held; tick 8 is the live line value.
  assign maj  = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      s6        <= 1'b1;
      s7        <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      err_wait  <= 1'b0;
      push_req  <= 1'b0;
      push_word <= '0;
`ifdef UART_RX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        if (fall) state <= S_START;
      end else begin
        if (tick) begin
          div_cnt  <= '0;
          tick_cnt <= tick_cnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (tick && tick_cnt == 4'd6) s6 <= rx_s;
        if (tick && tick_cnt == 4'd7) s7 <= rx_s;
        if (state == S_STOP && err_wait) begin
          if (rx_s) begin
            err_wait <= 1'b0;
            state    <= S_IDLE;
          end
        end else if (mid) begin
          case (state)
            S_START: begin
              if (maj) begin
                state <= S_IDLE;
              end else begin
                state   <= S_DATA;
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                par     <= 1'b0;
`endif
              end
            end
            S_DATA: begin
              shreg <= {maj, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
              par   <= par ^ maj;
`endif
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
`ifdef UART_RX_PARITY_EN
            // par becomes 1 here exactly when data+parity has odd weight.
            S_PARITY: begin
              par   <= par ^ maj;
              state <= S_STOP;
            end
`endif
            S_STOP: begin
              if (!maj) begin
                err_wait <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                push_req <= ~par;
`else
                push_req <= 1'b1;
`endif
                push_word <= shreg;
                state     <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign ferr_set = (state == S_STOP) && !err_wait && mid && !maj;
  assign ovf_set  = push_req && full && !pop;
`ifdef UART_RX_PARITY_EN
  assign perr_set = (state == S_PARITY) && mid && (par ^ maj);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr_err) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set) frame_err <= 1'b1;
      if (ovf_set)  overflow  <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        parity_err <= 1'b0;
    else if (clr_err)  parity_err <= 1'b0;
    else if (perr_set) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign valid   = (wptr != rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = valid && ready;
  assign do_push = push_req && (!full || pop);
  assign wptr_n  = wptr + PW'(do_push);
  assign rptr_n  = rptr + PW'(pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_word;
  end

  // dato is the registered head; a push into an emptying FIFO bypasses memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      dato <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if (wptr_n != rptr_n) begin
        dato <= (do_push && rptr_n == wptr) ? push_word : mem[rptr_n[AW-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based model.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ   = 50000000;
  localparam int BAUD       = 115200;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV        = CLK_FREQ / (16 * BAUD);
  localparam int BIT_CLKS   = 16 * DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx = 1'b1;
  logic                 ready = 1'b0;
  logic                 clr_err = 1'b0;
  logic [DATA_BITS-1:0] dato;
  logic                 valid, frame_err, overflow, parity_err;

  always #10 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dato      (dato),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .parity_err(parity_err),
    .clr_err   (clr_err)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] popped[$];
  logic exp_ferr = 1'b0;
  logic exp_ovf  = 1'b0;
  logic exp_perr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popped_at(input int i);
    if (i < popped.size()) return int'(popped[i]);
    return -1;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model update happens at frame start: words already delivered decide overflow.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    logic good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    if (bad_par) begin
      good     = 1'b0;
      exp_perr = 1'b1;
    end
`endif
    if (!stop_bit) exp_ferr = 1'b1;
    if (good) begin
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(d);
    end
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    wait_clks(BIT_CLKS);
`endif
    rx = stop_bit;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err  = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL valid_no_word: valid=1 dato=%0h, expected valid=0", dato);
        end else begin
          tests++;
          if (dato !== exp_q[0]) begin
            fails++;
            $display("FAIL head_word: dato=%0h expected %0h", dato, exp_q[0]);
          end
          if (ready) begin
            popped.push_back(dato);
            void'(exp_q.pop_front());
          end
        end
      end
      if (frame_err)  check("frame_err_spurious", int'(frame_err), int'(exp_ferr));
      if (overflow)   check("overflow_spurious", int'(overflow), int'(exp_ovf));
      if (parity_err) check("parity_err_spurious", int'(parity_err), int'(exp_perr));
    end
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pd;
    int n0;

    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_dato", int'(dato), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_parity_err", int'(parity_err), 0);
    rst_n = 1'b1;
    wait_clks(10);

    // Two back-to-back words with the consumer always ready.
    ready = 1'b1;
    popped.delete();
    send_frame(8'h61, 1'b1, 1'b0);
    send_frame(8'h30, 1'b1, 1'b0);
    drain("two_words");
    check("two_count", popped.size(), 2);
    check("two_first", popped_at(0), 'h61);
    check("two_second", popped_at(1), 'h30);
    check("two_ferr", int'(frame_err), 0);
    check("two_ovf", int'(overflow), 0);

    // Nine frames into a stalled FIFO: eight held, the ninth dropped.
    ready = 1'b0;
    popped.delete();
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    wait_clks(4);
    check("full_model_held", exp_q.size(), 8);
    check("full_valid", int'(valid), 1);
    check("full_overflow", int'(overflow), 1);
    check("full_head", int'(dato), 0);
    ready = 1'b1;
    drain("full");
    check("full_pop_count", popped.size(), 8);
    for (int i = 0; i < 8; i++) check("full_order", popped_at(i), i);
    pulse_clr();
    check("ovf_cleared", int'(overflow), 0);

    // Short low glitch is rejected as a false start.
    n0 = popped.size();
    rx = 1'b0;
    wait_clks(4 * DIV);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_valid", int'(valid), 0);
    check("glitch_ferr", int'(frame_err), 0);
    check("glitch_ovf", int'(overflow), 0);
    check("glitch_nothing", popped.size(), n0);

    // Low stop bit.
    send_frame(8'h55, 1'b0, 1'b0);
    wait_clks(4);
    check("ferr_set", int'(frame_err), 1);
    check("ferr_nothing", int'(valid), 0);
    check("ferr_pops", popped.size(), n0);
    pulse_clr();
    check("ferr_cleared", int'(frame_err), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(4);
    check("perr_set", int'(parity_err), 1);
    check("perr_dropped", int'(valid), 0);
    pulse_clr();
    check("perr_cleared", int'(parity_err), 0);
    popped.delete();
    send_frame(8'h07, 1'b1, 1'b0);
    drain("par_good");
    check("par_good_word", popped_at(0), 'h07);
`endif

    // Reset during the fourth data bit of a frame.
    popped.delete();
    pd = 8'hF2;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = pd[i];
      wait_clks(BIT_CLKS);
    end
    rx = pd[3];
    wait_clks(BIT_CLKS / 2);
    rst_n = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
    #2;
    check("midrst_dato", int'(dato), 0);
    check("midrst_valid", int'(valid), 0);
    wait_clks(3);
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    check("midrst_no_word", int'(valid), 0);
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("after_rst");
    check("after_rst_count", popped.size(), 1);
    check("after_rst_word", popped_at(0), 'hA5);

    // Random words, gaps and consumer stalls.
    popped.delete();
    for (int k = 0; k < 3; k++) begin
      ready = 1'($urandom_range(0, 1));
      wait_clks($urandom_range(1, 60));
      send_frame(8'($urandom), 1'b1, 1'b0);
    end
    ready = 1'b1;
    drain("random");
    check("random_count", popped.size(), 3);
    check("end_ferr", int'(frame_err), 0);
    check("end_ovf", int'(overflow), 0);
    check("end_perr", int'(parity_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
